// File: rtl/wakeup_sched.sv
// Wakeup tag scheduler: one fixed-latency delay line per functional unit that
// broadcasts destination tags after LAT cycles, with branch-mask kill/clear and flush.
module wakeup_sched #(
   parameter int                  NUM_FU   = 4,
   parameter int                  TAG_W    = 7,
   parameter int                  CKPT     = 8,
   parameter int                  CKPT_LOG = 3,
   parameter int                  MAX_LAT  = 8,
   parameter logic [4*NUM_FU-1:0] LAT_VEC  = {4'd1, 4'd3, 4'd1, 4'd4}
) (
   input  logic                      clock,
   input  logic                      reset_n,
   input  logic                      flush_i,
   input  logic                      ctrlVerified_i,
   input  logic                      ctrlMispredict_i,
   input  logic [CKPT_LOG-1:0]       ctrlSMTid_i,
   input  logic [NUM_FU-1:0]         grantValid_i,
   input  logic [NUM_FU*TAG_W-1:0]   grantDest_i,
   input  logic [NUM_FU*CKPT-1:0]    grantMask_i,
   output logic [NUM_FU-1:0]         tagValid_o,
   output logic [NUM_FU*TAG_W-1:0]   tag_o,
   output logic [NUM_FU*4-1:0]       inflight_o
);

   logic            w_kill_en;
   logic [CKPT-1:0] w_clr_vec;

   always_comb begin
      w_kill_en = ctrlVerified_i & ctrlMispredict_i;
      w_clr_vec = '0;
      if (ctrlVerified_i && !ctrlMispredict_i) begin
         w_clr_vec[ctrlSMTid_i] = 1'b1;
      end
   end

   for (genvar g = 0; g < NUM_FU; g++) begin : g_fu
      localparam int RAW = int'(LAT_VEC[4*g +: 4]);
      localparam int LAT = (RAW < 1) ? 1 : ((RAW > MAX_LAT) ? MAX_LAT : RAW);

      logic [LAT-1:0]            w_vld;
      logic [LAT-1:0]            w_kill;
      logic [LAT-1:0][TAG_W-1:0] w_tg;
      logic [LAT-1:0][CKPT-1:0]  w_msk;
      logic [CKPT-1:0]           w_gmask;
      logic                      w_load;
      logic [31:0]               w_ones;

      always_comb begin
         w_gmask = grantMask_i[CKPT*g +: CKPT];
         w_load  = grantValid_i[g] & ~(w_kill_en & w_gmask[ctrlSMTid_i]) & ~flush_i;
      end

      // Each stage owns its registers; the packed w_* views let neighbours and outputs read them.
      for (genvar k = 0; k < LAT; k++) begin : g_st
         logic             r_valid;
         logic [TAG_W-1:0] r_tag;
         logic [CKPT-1:0]  r_mask;
         logic             w_nv;
         logic [TAG_W-1:0] w_nt;
         logic [CKPT-1:0]  w_nm;

         if (k == 0) begin : g_src
            always_comb begin
               w_nv = w_load;
               w_nt = grantDest_i[TAG_W*g +: TAG_W];
               w_nm = w_gmask;
            end
         end else begin : g_src
            always_comb begin
               w_nv = w_vld[k-1] & ~w_kill[k-1] & ~flush_i;
               w_nt = w_tg[k-1];
               w_nm = w_msk[k-1];
            end
         end

         always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
               r_valid <= 1'b0;
               r_tag   <= '0;
               r_mask  <= '0;
            end else if (w_nv) begin
               r_valid <= 1'b1;
               r_tag   <= w_nt;
               r_mask  <= w_nm & ~w_clr_vec;
            end else begin
               r_valid <= 1'b0;
               r_tag   <= '0;
               r_mask  <= '0;
            end
         end

         assign w_vld[k]  = r_valid;
         assign w_tg[k]   = r_tag;
         assign w_msk[k]  = r_mask;
         assign w_kill[k] = w_kill_en & r_mask[ctrlSMTid_i];
      end

      always_comb begin
         tagValid_o[g]                = w_vld[LAT-1] & ~w_kill[LAT-1] & ~flush_i;
         tag_o[TAG_W*g +: TAG_W]      = tagValid_o[g] ? w_tg[LAT-1] : '0;
         w_ones                       = 32'($countones(w_vld));
         inflight_o[4*g +: 4]         = (w_ones > 32'd15) ? 4'd15 : w_ones[3:0];
      end
   end

endmodule

// File: doc/wakeup_sched.md
WAKEUP_SCHED -- requirements
Module: wakeup_sched

Interface
REQ-001 Parameter NUM_FU, 4, number of functional units (FU) whose destination tags are broadcast.
REQ-002 Parameter TAG_W, 7, physical register tag width.
REQ-003 Parameter CKPT, 8, number of branch checkpoints (branch-mask width).
REQ-004 Parameter CKPT_LOG, 3, checkpoint index width.
REQ-005 Parameter MAX_LAT, 8, maximum supported FU latency in cycles.
REQ-006 Parameter LAT_VEC, {4'd1,4'd3,4'd1,4'd4}, packed 4-bit latency per FU (FU i at bits [4i+3:4i]); each value SHALL be in 1..MAX_LAT.
REQ-007 clock  input  1  rising-edge clock.
REQ-008 reset_n  input  1  asynchronous, active-low reset.
REQ-009 flush_i  input  1  synchronous kill of every in-flight entry.
REQ-010 ctrlVerified_i  input  1  branch resolution valid this cycle.
REQ-011 ctrlMispredict_i  input  1  resolved branch mispredicted (qualified by ctrlVerified_i).
REQ-012 ctrlSMTid_i  input  CKPT_LOG  checkpoint index of the resolved branch.
REQ-013 grantValid_i  input  NUM_FU  per-FU grant valid.
REQ-014 grantDest_i  input  NUM_FU*TAG_W  per-FU destination tag, FU i at [TAG_W*i +: TAG_W].
REQ-015 grantMask_i  input  NUM_FU*CKPT  per-FU branch mask, FU i at [CKPT*i +: CKPT].
REQ-016 tagValid_o  output  NUM_FU  per-FU wakeup broadcast valid.
REQ-017 tag_o  output  NUM_FU*TAG_W  per-FU broadcast tag; zero when the matching valid bit is 0.
REQ-018 inflight_o  output  NUM_FU*4  per-FU count of live entries in that FU's delay line.

Function
REQ-019 Kill condition K(mask) = ctrlVerified_i & ctrlMispredict_i & mask[ctrlSMTid_i], evaluated combinationally in the current cycle.
REQ-020 Each FU i SHALL own a delay line of exactly LAT_i stages, with (valid, tag, mask) per stage; unused stages up to MAX_LAT SHALL NOT be generated.
REQ-021 Latency: a grant presented in cycle c with grantValid_i[i]=1 SHALL appear on tagValid_o[i]/tag_o[i] in cycle c+LAT_i, unless it is killed earlier.
REQ-022 Stage 0 load: valid <= grantValid_i[i] & ~K(grantMask_i[i]) & ~flush_i; tag and mask are loaded only when valid is loaded; otherwise tag and mask SHALL be loaded as 0.
REQ-023 Stage k->k+1 shift: the entry advances each cycle; it SHALL be zeroed if K(stage k mask) or flush_i holds.
REQ-024 Output: tagValid_o[i] = last-stage valid & ~K(last-stage mask) & ~flush_i; tag_o[i] = last-stage tag when tagValid_o[i]=1, else 0.
REQ-025 Mask clear: when ctrlVerified_i=1 and ctrlMispredict_i=0, bit ctrlSMTid_i SHALL be cleared in the mask of every stage as it shifts, and in the mask captured at stage 0 from grantMask_i.
REQ-026 A kill and a mask clear never apply in the same cycle; a correct resolution of checkpoint j SHALL NOT affect an entry that does not carry bit j.
REQ-027 inflight_o[i] SHALL equal the number of set valid bits across FU i's stages (registered state, excluding the current-cycle input), saturating at 15.
REQ-028 All FUs operate independently; simultaneous grants on every FU in the same cycle SHALL all be tracked with no drops.
REQ-029 The delay lines are fully pipelined: a new grant is accepted on every FU every cycle with no backpressure.
REQ-030 A grant and a flush_i in the same cycle: the grant SHALL be dropped.

Reset
REQ-031 While reset_n=0, all stage valid, tag and mask bits SHALL be 0, so that tagValid_o=0, tag_o=0 and inflight_o=0.
REQ-032 Asserting reset_n=0 mid-operation SHALL discard every in-flight entry immediately; no stale broadcast SHALL follow deassertion.

Verification
REQ-033 FU0 (LAT 4) grant tag 0x15, mask 0, cycle 10 -> tagValid_o[0]=1, tag 0x15 at cycle 14 only; inflight_o[0]=1 in cycles 11-14.
REQ-034 FU1 (LAT 1) and FU3 (LAT 1) grants in cycle 5 with tags 0x03/0x7F -> both broadcast in cycle 6; FU2 (LAT 3) grant in cycle 5 -> broadcast in cycle 8.
REQ-035 FU0 grant with mask 0x04 in cycle 0; mispredict of SMTid 2 in cycle 2 -> no broadcast in cycle 4; inflight_o[0]=0 from cycle 3; same stimulus with SMTid 3 -> broadcast in cycle 4.
REQ-036 FU0 grant with mask 0x04 in cycle 0; correct resolution of SMTid 2 in cycle 1; mispredict of SMTid 2 in cycle 3 -> broadcast still occurs in cycle 4.
REQ-037 Back-to-back FU0 grants in cycles 0-3 with tags 1-4, then flush_i in cycle 3 -> no broadcasts in cycles 3-7; inflight_o[0]=0 in cycle 4.
REQ-038 reset_n pulsed low in cycle 2 after an FU0 grant in cycle 0 -> outputs 0 during reset, and no broadcast at cycle 4.
